// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: address map, FSM states,
// response payload and the byte-strobe merge helper.
package clint_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NBYTES = 8;

  localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] rdata;
  } clint_rsp_t;

  // Replace each byte of old_v whose strobe is set with the matching byte of wdata.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0]   old_v,
                                                 input logic [XLEN-1:0]   wdata,
                                                 input logic [NBYTES-1:0] wstrb);
    logic [XLEN-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Free-running mtime counter with a tick divider and a byte-strobed write port.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [NBYTES-1:0] wstrb_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   mtime_o
);

  localparam int unsigned     DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [XLEN-1:0]  mtime_q, mtime_d, mtime_inc;
  logic             tick;

  // Written bytes override the incremented value; unwritten bytes keep the carry.
  always_comb begin
    tick      = (div_q == DIV_MAX);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    mtime_inc = mtime_q + XLEN'(tick);
    mtime_d   = mtime_inc;
    if (we_i) mtime_d = byte_merge(mtime_inc, wdata_i, wstrb_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      mtime_q <= '0;
    end else begin
      div_q   <= div_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip/mtimecmp/mtime registers behind a single-beat
// valid/ready request/response port, driving the msip and mtip lines.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        msip,
  output logic        mtip
);

  state_e          state_q, state_d;
  clint_rsp_t      rsp_q, rsp_d;
  logic            msip_q, msip_d;
  logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0] mtime;
  logic [XLEN-1:0] offset;
  logic            in_win, aligned, hit_msip, hit_cmp, hit_mtime, hit_any;
  logic            mtime_we;
  logic [XLEN-1:0] rdata_c;

  // Address decode: 64 KiB window, 8-byte aligned, three mapped offsets.
  always_comb begin
    offset    = req_addr - CLINT_BASE;
    in_win    = (req_addr >= CLINT_BASE) && (offset[63:16] == 48'h0);
    aligned   = (req_addr[2:0] == 3'b000);
    hit_msip  = in_win && aligned && (offset[15:0] == OFF_MSIP);
    hit_cmp   = in_win && aligned && (offset[15:0] == OFF_MTIMECMP);
    hit_mtime = in_win && aligned && (offset[15:0] == OFF_MTIME);
    hit_any   = hit_msip || hit_cmp || hit_mtime;
    rdata_c   = '0;
    if (!req_wen) begin
      if (hit_msip)  rdata_c = {63'b0, msip_q};
      if (hit_cmp)   rdata_c = mtimecmp_q;
      if (hit_mtime) rdata_c = mtime;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_d      = rsp_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_RESP;
          rsp_d.err   = !hit_any;
          rsp_d.rdata = rdata_c;
          if (req_wen && hit_msip && req_wstrb[0]) msip_d = req_wdata[0];
          if (req_wen && hit_cmp) mtimecmp_d = byte_merge(mtimecmp_q, req_wdata, req_wstrb);
          mtime_we = req_wen && hit_mtime;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rsp_q      <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mtime_we),
    .wstrb_i(req_wstrb),
    .wdata_i(req_wdata),
    .mtime_o(mtime)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign msip      = msip_q;
  assign mtip      = (mtime >= mtimecmp_q);

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV=1 and 4) share one request bus and
// are compared against a behavioural register-map model.
module tb_clint;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam int unsigned KDIV [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_ready = 1'b1;

  logic [1:0]  req_ready_a, rsp_valid_a, rsp_err_a, msip_a, mtip_a;
  logic [63:0] rsp_rdata_a [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clint #(.CLINT_BASE(BASE), .TICK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_ready(req_ready_a[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a[0]),
    .rsp_err(rsp_err_a[0]), .msip(msip_a[0]), .mtip(mtip_a[0])
  );

  clint #(.CLINT_BASE(BASE), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_ready(req_ready_a[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a[1]),
    .rsp_err(rsp_err_a[1]), .msip(msip_a[1]), .mtip(mtip_a[1])
  );

  // ---------------- reference model ----------------
  logic [63:0] m_mtime [2];
  int unsigned m_cnt [2];
  logic [63:0] m_rdata [2];
  logic [63:0] m_cmp = '1;
  logic        m_msip = 1'b0;
  logic        m_err = 1'b0;

  // 0 = unmapped/misaligned, 1 = msip, 2 = mtimecmp, 3 = mtime
  function automatic int region(input logic [63:0] a);
    if (a < BASE || a > BASE + 64'hFFFF) return 0;
    if (a[2:0] != 3'b000) return 0;
    if (a == A_MSIP) return 1;
    if (a == A_CMP)  return 2;
    if (a == A_TIME) return 3;
    return 0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int r;
    logic [63:0] nxt;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_mtime[k] = '0; m_cnt[k] = 0; m_rdata[k] = '0;
      end
      m_cmp = '1; m_msip = 1'b0; m_err = 1'b0;
    end else begin
      r = region(req_addr);
      if (req_valid) begin
        m_err = (r == 0);
        for (int k = 0; k < 2; k++)
          m_rdata[k] = (req_wen || r == 0) ? 64'h0 :
                       (r == 1) ? {63'b0, m_msip} : (r == 2) ? m_cmp : m_mtime[k];
      end
      for (int k = 0; k < 2; k++) begin
        nxt = m_mtime[k];
        if (m_cnt[k] == KDIV[k] - 1) begin
          nxt = nxt + 64'd1; m_cnt[k] = 0;
        end else m_cnt[k] = m_cnt[k] + 1;
        if (req_valid && req_wen && r == 3) nxt = merge(nxt, req_wdata, req_wstrb);
        m_mtime[k] = nxt;
      end
      if (req_valid && req_wen && r == 1 && req_wstrb[0]) m_msip = req_wdata[0];
      if (req_valid && req_wen && r == 2) m_cmp = merge(m_cmp, req_wdata, req_wstrb);
    end
  end

  // One request/response on the shared bus; entered and left at a negedge.
  task automatic bus_xfer(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb, input int hold, input string tag,
                          output logic [63:0] rd0, output logic [63:0] rd1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready_a[k] !== 1'b1) begin
        errors++; $display("FAIL %s[%0d] req_ready idle: got %b want 1", tag, k, req_ready_a[k]);
      end
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rsp_valid_a[k] !== 1'b1 || req_ready_a[k] !== 1'b0) begin
          errors++; $display("FAIL %s[%0d] rsp_valid/req_ready cyc%0d: got %b/%b want 1/0",
                             tag, k, h, rsp_valid_a[k], req_ready_a[k]);
        end
        checks++;
        if (rsp_rdata_a[k] !== m_rdata[k] || rsp_err_a[k] !== m_err) begin
          errors++; $display("FAIL %s[%0d] rdata/err cyc%0d: got %h/%b want %h/%b",
                             tag, k, h, rsp_rdata_a[k], rsp_err_a[k], m_rdata[k], m_err);
        end
        checks++;
        if (msip_a[k] !== m_msip || mtip_a[k] !== (m_mtime[k] >= m_cmp)) begin
          errors++; $display("FAIL %s[%0d] msip/mtip: got %b/%b want %b/%b", tag, k,
                             msip_a[k], mtip_a[k], m_msip, (m_mtime[k] >= m_cmp));
        end
      end
    end
    rd0 = rsp_rdata_a[0]; rd1 = rsp_rdata_a[1];
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rsp_valid_a[k] !== 1'b0 || req_ready_a[k] !== 1'b1) begin
        errors++; $display("FAIL %s[%0d] return idle: got valid=%b ready=%b want 0/1",
                           tag, k, rsp_valid_a[k], req_ready_a[k]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rsp_valid_a[k] !== 1'b0 || req_ready_a[k] !== 1'b1 || rsp_err_a[k] !== 1'b0 ||
          rsp_rdata_a[k] !== 64'h0 || msip_a[k] !== 1'b0 || mtip_a[k] !== 1'b0) begin
        errors++; $display("FAIL reset[%0d]: got v=%b r=%b e=%b d=%h msip=%b mtip=%b want 0 1 0 0 0 0",
                           k, rsp_valid_a[k], req_ready_a[k], rsp_err_a[k], rsp_rdata_a[k],
                           msip_a[k], mtip_a[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mtime_read();
    logic [63:0] r0, r1;
    repeat (10) @(negedge clk);
    bus_xfer(1'b0, A_TIME, 64'h0, 8'h00, 0, "mtime_read", r0, r1);
    checks++;
    if (r0 !== 64'd10 || r1 !== 64'd2) begin
      errors++; $display("FAIL mtime_after_10: got %0d/%0d want 10/2", r0, r1);
    end
  endtask

  task automatic test_msip();
    logic [63:0] r0, r1;
    bus_xfer(1'b1, A_MSIP, 64'h1, 8'h01, 0, "msip_set", r0, r1);
    checks++;
    if (msip_a !== 2'b11) begin errors++; $display("FAIL msip_set: got %b want 11", msip_a); end
    bus_xfer(1'b0, A_MSIP, 64'h0, 8'h00, 0, "msip_rd1", r0, r1);
    checks++;
    if (r0 !== 64'h1) begin errors++; $display("FAIL msip_rd1: got %h want 1", r0); end
    bus_xfer(1'b1, A_MSIP, 64'h0, 8'h00, 0, "msip_nostrb", r0, r1);
    checks++;
    if (msip_a !== 2'b11) begin errors++; $display("FAIL msip_nostrb: got %b want 11", msip_a); end
    bus_xfer(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, "msip_clr", r0, r1);
    checks++;
    if (msip_a !== 2'b00) begin errors++; $display("FAIL msip_clr: got %b want 00", msip_a); end
    bus_xfer(1'b0, A_MSIP, 64'h0, 8'h00, 0, "msip_rd0", r0, r1);
    checks++;
    if (r0 !== 64'h0) begin errors++; $display("FAIL msip_rd0: got %h want 0", r0); end
  endtask

  task automatic test_mtip();
    logic [63:0] r0, r1, tgt;
    tgt = m_mtime[0] + 64'd20;
    bus_xfer(1'b1, A_CMP, tgt, 8'hFF, 0, "cmp_set", r0, r1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (mtip_a[0] !== (m_mtime[0] >= tgt) || mtip_a[1] !== (m_mtime[1] >= tgt)) begin
        errors++; $display("FAIL mtip_cyc%0d: got %b want %b%b", c, mtip_a,
                           (m_mtime[1] >= tgt), (m_mtime[0] >= tgt));
      end
    end
    checks++;
    if (mtip_a[0] !== 1'b1) begin errors++; $display("FAIL mtip_reached: got %b want 1", mtip_a[0]); end
    bus_xfer(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "cmp_max", r0, r1);
    checks++;
    if (mtip_a !== 2'b00) begin errors++; $display("FAIL mtip_cleared: got %b want 00", mtip_a); end
  endtask

  task automatic test_wrap();
    logic [63:0] r0, r1;
    bus_xfer(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, "wrap_wr", r0, r1);
    for (int i = 0; i < 6; i++) bus_xfer(1'b0, A_TIME, 64'h0, 8'h00, 0, "wrap_rd", r0, r1);
    checks++;
    if (r0 !== 64'd9 || r1 > 64'd3) begin
      errors++; $display("FAIL wrap_final: got %h/%h want 9/<=3", r0, r1);
    end
  endtask

  task automatic test_partial_write();
    logic [63:0] r0, r1;
    bus_xfer(1'b1, A_TIME, 64'h0000_0005_FFFF_FFFE, 8'hFF, 0, "part_full", r0, r1);
    bus_xfer(1'b1, A_TIME, 64'h0000_0000_1234_5678, 8'h0F, 0, "part_low", r0, r1);
    bus_xfer(1'b0, A_TIME, 64'h0, 8'h00, 0, "part_rd", r0, r1);
    checks++;
    if (r0 !== 64'h0000_0006_1234_5679) begin
      errors++; $display("FAIL part_carry: got %h want 0000000612345679", r0);
    end
  endtask

  task automatic test_errors();
    logic [63:0] r0, r1;
    bus_xfer(1'b0, BASE + 64'h4, 64'h0, 8'h00, 0, "err_misal", r0, r1);
    bus_xfer(1'b0, BASE + 64'h1000, 64'h0, 8'h00, 0, "err_hole", r0, r1);
    bus_xfer(1'b1, 64'h0000_0000_0300_0000, 64'h0, 8'hFF, 0, "err_outside", r0, r1);
    bus_xfer(1'b1, A_CMP + 64'h4, 64'h0, 8'hFF, 0, "err_cmp_misal", r0, r1);
    bus_xfer(1'b1, A_MSIP + 64'h10000, 64'h1, 8'hFF, 0, "err_alias", r0, r1);
    bus_xfer(1'b0, BASE - 64'h8, 64'h0, 8'h00, 0, "err_below", r0, r1);
    checks++;
    if (rsp_err_a !== 2'b11 || r0 !== 64'h0) begin
      errors++; $display("FAIL err_flag: got err=%b data=%h want 11/0", rsp_err_a, r0);
    end
    bus_xfer(1'b0, A_CMP, 64'h0, 8'h00, 0, "err_cmp_kept", r0, r1);
    checks++;
    if (r0 !== 64'hFFFF_FFFF_FFFF_FFFF || msip_a !== 2'b00) begin
      errors++; $display("FAIL err_nochange: got cmp=%h msip=%b want all-ones/00", r0, msip_a);
    end
  endtask

  task automatic test_hold();
    logic [63:0] r0, r1;
    bus_xfer(1'b1, A_CMP, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "hold_wr", r0, r1);
    bus_xfer(1'b0, A_CMP, 64'h0, 8'h00, 5, "hold_rd", r0, r1);
    checks++;
    if (r0 !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL hold_data: got %h want 0123456789abcdef", r0);
    end
  endtask

  task automatic test_random();
    logic [63:0] r0, r1, a, d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: a = A_MSIP;
        1: a = A_CMP;
        2: a = A_TIME;
        3: a = BASE + {48'h0, 16'($urandom) & 16'hFFF8};
        4: a = A_CMP + 64'($urandom_range(1, 7));
        5: a = BASE + 64'h10000 + 64'($urandom);
        default: a = BASE - 64'($urandom_range(1, 4096));
      endcase
      d = {$urandom, $urandom};
      bus_xfer(1'($urandom), a, d, 8'($urandom), $urandom_range(0, 2), "random", r0, r1);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r0, r1;
    bus_xfer(1'b1, A_MSIP, 64'h1, 8'h01, 0, "rstmid_set", r0, r1);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_MSIP; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid_a !== 2'b11) begin errors++; $display("FAIL rstmid_resp: got %b want 11", rsp_valid_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid_a !== 2'b00 || msip_a !== 2'b00 || mtip_a !== 2'b00 || req_ready_a !== 2'b11) begin
      errors++; $display("FAIL rstmid_abort: got valid=%b msip=%b mtip=%b ready=%b want 00 00 00 11",
                         rsp_valid_a, msip_a, mtip_a, req_ready_a);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    bus_xfer(1'b0, A_MSIP, 64'h0, 8'h00, 0, "rstmid_msip", r0, r1);
    bus_xfer(1'b0, A_TIME, 64'h0, 8'h00, 0, "rstmid_time", r0, r1);
    checks++;
    if (r0 !== 64'd2) begin errors++; $display("FAIL rstmid_mtime: got %0d want 2", r0); end
  endtask

  initial begin
    test_reset();
    test_mtime_read();
    test_msip();
    test_mtip();
    test_wrap();
    test_partial_write();
    test_errors();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
